// File: rtl/bcd_scan_counter.sv
// Purpose: 4-digit BCD up/down counter clocked by a synchronised data-level tick, scanned to one LS48 decoder.
// Latency: count moves SYNC_STAGES+1 posedges after tick_in rises; display outputs track count in the same edge.
// Backpressure: none; ticks arriving with en=0 or clr=1 are dropped. Optional macro: LEAD_ZERO_BLANK_EN.
module bcd_scan_counter #(
   parameter int SCAN_DIV    = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_50M,
   input  logic        rst_n,
   input  logic        tick_in,
   input  logic        en,
   input  logic        up_dn,
   input  logic        clr,
   output logic [15:0] count,
   output logic        wrap,
   output logic [3:0]  digit_sel_n,
   output logic [3:0]  bcd_out,
   output logic        blank_n
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   pulse;
   logic [SCAN_W-1:0]      scan_cnt;
   logic                   scan_last;
   logic [1:0]             idx;
   logic [1:0]             idx_nxt;
   logic [15:0]            count_nxt;
   logic                   wrap_nxt;
   logic [16:0]            bcd_step_res;
   logic [3:0]             dsel_nxt;
   logic [3:0]             bcd_nxt;
   logic                   blank_nxt;

   // Single BCD increment/decrement across all four digits; bit 16 flags a full wrap.
   function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
      logic [15:0] r;
      logic        carry;
      logic [3:0]  nib;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nib = v[4*i +: 4];
         if (carry) begin
            if (up) begin
               if (nib == 4'd9) begin
                  r[4*i +: 4] = 4'd0;
               end else begin
                  r[4*i +: 4] = nib + 4'd1;
                  carry       = 1'b0;
               end
            end else begin
               if (nib == 4'd0) begin
                  r[4*i +: 4] = 4'd9;
               end else begin
                  r[4*i +: 4] = nib - 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return {carry, r};
   endfunction

   assign pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

   // Synchroniser chain plus edge flop; all ones at reset so a tick held high through reset never fires.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         sync_q <= '1;
         edge_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Next count: clear beats a tick, a tick only counts when enabled, otherwise hold.
   always_comb begin
      count_nxt    = count;
      wrap_nxt     = 1'b0;
      bcd_step_res = bcd_step(count, up_dn);
      if (clr) begin
         count_nxt = '0;
      end else if (pulse && en) begin
         count_nxt = bcd_step_res[15:0];
         wrap_nxt  = bcd_step_res[16];
      end
   end

   // Count register with its wrap flag, so wrap is high while the wrapped value is on count.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= count_nxt;
         wrap  <= wrap_nxt;
      end
   end

   assign scan_last = (scan_cnt == SCAN_LAST);
   assign idx_nxt   = scan_last ? idx + 2'd1 : idx;

   // Free-running scan timer; the digit index steps once per SCAN_DIV cycles regardless of en/clr.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
      end else begin
         scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
         idx      <= idx_nxt;
      end
   end

`ifdef LEAD_ZERO_BLANK_EN
   logic lz1, lz2, lz3;
   // A digit is a leading zero when it and every higher digit of the next count are zero.
   always_comb begin
      lz3       = (count_nxt[15:12] == 4'd0);
      lz2       = lz3 && (count_nxt[11:8] == 4'd0);
      lz1       = lz2 && (count_nxt[7:4] == 4'd0);
      blank_nxt = ~(((idx_nxt == 2'd1) && lz1) ||
                    ((idx_nxt == 2'd2) && lz2) ||
                    ((idx_nxt == 2'd3) && lz3));
   end
`else
   assign blank_nxt = 1'b1;
`endif

   // Display values come from next-state index and count, so they line up with idx/count edge for edge.
   always_comb begin
      dsel_nxt = ~(4'b0001 << idx_nxt);
      bcd_nxt  = count_nxt[{idx_nxt, 2'b00} +: 4];
   end

   // Enable, nibble and blank share one register stage so they switch together without glitches.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         digit_sel_n <= 4'b1110;
         bcd_out     <= 4'd0;
         blank_n     <= 1'b1;
      end else begin
         digit_sel_n <= dsel_nxt;
         bcd_out     <= bcd_nxt;
         blank_n     <= blank_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Purpose: scoreboard bench for bcd_scan_counter with SCAN_DIV=4, SYNC_STAGES=2.
// Latency: expectations are queued with the cycle they are due; a negedge monitor pops and compares.
// Backpressure: none; stimulus runs open-loop, every wait is bounded.
module tb_bcd_scan_counter;

   logic        clk_50M = 1'b0;
   logic        rst_n   = 1'b0;
   logic        tick_in = 1'b0;
   logic        en      = 1'b1;
   logic        up_dn   = 1'b1;
   logic        clr     = 1'b0;
   logic [15:0] count;
   logic        wrap;
   logic [3:0]  digit_sel_n;
   logic [3:0]  bcd_out;
   logic        blank_n;

   bcd_scan_counter #(.SCAN_DIV(4), .SYNC_STAGES(2)) dut (
      .clk_50M     (clk_50M),
      .rst_n       (rst_n),
      .tick_in     (tick_in),
      .en          (en),
      .up_dn       (up_dn),
      .clr         (clr),
      .count       (count),
      .wrap        (wrap),
      .digit_sel_n (digit_sel_n),
      .bcd_out     (bcd_out),
      .blank_n     (blank_n)
   );

   always #10 clk_50M = ~clk_50M;

   typedef struct {
      int          cyc;
      int          tag;
      int          kind;
      logic [15:0] val;
   } exp_t;

   exp_t sbq[$];
   int   cyc     = 0;
   int   rst_cyc = 0;
   int   n_chk   = 0;
   int   n_pass  = 0;

`ifdef LEAD_ZERO_BLANK_EN
   localparam logic [3:0] MASK_0007 = 4'b0001;
`else
   localparam logic [3:0] MASK_0007 = 4'b1111;
`endif

   always @(posedge clk_50M) cyc <= cyc + 1;

   function automatic string kname(input int kind);
      case (kind)
         0:       return "count";
         1:       return "wrap";
         2:       return "digit_sel_n";
         3:       return "bcd_out";
         default: return "blank_n";
      endcase
   endfunction

   function automatic logic [15:0] actual(input int kind);
      case (kind)
         0:       return count;
         1:       return {15'd0, wrap};
         2:       return {12'd0, digit_sel_n};
         3:       return {12'd0, bcd_out};
         default: return {15'd0, blank_n};
      endcase
   endfunction

   // Monitor: compare every expectation due in this cycle, flag any that slipped past unchecked.
   always @(negedge clk_50M) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].cyc <= cyc) begin
            n_chk++;
            if (sbq[i].cyc != cyc) begin
               $display("FAIL t%0d %s: not sampled at cycle %0d (now %0d)",
                        sbq[i].tag, kname(sbq[i].kind), sbq[i].cyc, cyc);
            end else if (actual(sbq[i].kind) !== sbq[i].val) begin
               $display("FAIL t%0d %s @cyc %0d: got %h expected %h",
                        sbq[i].tag, kname(sbq[i].kind), cyc, actual(sbq[i].kind), sbq[i].val);
            end else begin
               n_pass++;
            end
            sbq.delete(i);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_50M);
      #1;
   endtask

   task automatic push(input int d, input int tag, input int kind, input logic [15:0] val);
      exp_t e;
      e.cyc  = cyc + d;
      e.tag  = tag;
      e.kind = kind;
      e.val  = val;
      sbq.push_back(e);
   endtask

   task automatic do_reset(input int n, input int tag);
      rst_n = 1'b0;
      push(1, tag, 0, 16'h0000);
      push(1, tag, 1, 16'h0000);
      push(1, tag, 2, 16'h000E);
      push(1, tag, 3, 16'h0000);
      push(1, tag, 4, 16'h0001);
      step(n);
      rst_n   = 1'b1;
      rst_cyc = cyc;
      step(3);
   endtask

   task automatic tick(input bit chk, input int tag, input logic [15:0] exp_cnt, input bit exp_wrap);
      tick_in = 1'b1;
      if (chk) begin
         push(3, tag, 0, exp_cnt);
         push(3, tag, 1, {15'd0, exp_wrap});
         push(4, tag, 1, 16'h0000);
      end
      step(3);
      tick_in = 1'b0;
      step(3);
   endtask

   task automatic scan_chk(input int n, input int tag, input logic [15:0] v, input logic [3:0] bmask);
      int         k;
      int         di;
      logic [3:0] ds;
      logic [3:0] nb;
      for (int j = 1; j <= n; j++) begin
         k  = cyc + j;
         di = ((k - rst_cyc) / 4) % 4;
         ds = ~(4'b0001 << di);
         nb = v[4*di +: 4];
         push(j, tag, 2, {12'd0, ds});
         push(j, tag, 3, {12'd0, nb});
         push(j, tag, 4, {15'd0, bmask[di]});
      end
      step(n);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      step(1);
      // t1: reset values after a 3-cycle reset
      push(3, 1, 0, 16'h0000);
      push(3, 1, 2, 16'h000E);
      do_reset(3, 1);

      // t2: first tick latency, then 12 ticks total
      push(2, 2, 0, 16'h0000);
      tick(1, 2, 16'h0001, 1'b0);
      for (int j = 2; j <= 12; j++) tick(j == 12, 2, 16'h0012, 1'b0);
      for (int j = 13; j <= 42; j++) tick(j == 42, 2, 16'h0042, 1'b0);
      // t1b: reset mid-count
      do_reset(1, 11);

      // t3: down wrap and up wrap
      up_dn = 1'b0;
      tick(1, 3, 16'h9999, 1'b1);
      up_dn = 1'b1;
      tick(1, 3, 16'h0000, 1'b1);

      // t4: clr coinciding with a wrapping pulse, then en=0 drops ticks
      up_dn = 1'b0;
      tick(1, 4, 16'h9999, 1'b1);
      up_dn = 1'b1;
      tick_in = 1'b1;
      step(2);
      clr = 1'b1;
      push(1, 4, 0, 16'h0000);
      push(1, 4, 1, 16'h0000);
      step(1);
      clr = 1'b0;
      push(1, 4, 0, 16'h0000);
      push(1, 4, 1, 16'h0000);
      step(1);
      tick_in = 1'b0;
      step(3);
      tick(1, 4, 16'h0001, 1'b0);
      en = 1'b0;
      for (int j = 0; j < 5; j++) tick(1, 14, 16'h0001, 1'b0);
      en = 1'b1;

      // t5: count to 0x1234 and check the digit scan
      for (int j = 2; j <= 1234; j++) tick(j == 1234, 5, 16'h1234, 1'b0);
      scan_chk(20, 5, 16'h1234, 4'b1111);

      // t6: leading-zero blanking at 0x0007
      clr = 1'b1;
      push(1, 6, 0, 16'h0000);
      step(1);
      clr = 1'b0;
      for (int j = 1; j <= 7; j++) tick(j == 7, 6, 16'h0007, 1'b0);
      scan_chk(16, 6, 16'h0007, MASK_0007);

      for (int k = 0; k < 50 && sbq.size() > 0; k++) step(1);
      while (sbq.size() > 0) begin
         n_chk++;
         $display("FAIL t%0d %s: expectation never checked", sbq[0].tag, kname(sbq[0].kind));
         void'(sbq.pop_front());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
